glb_stream_arbiter: RTL
=======================

Name: glb_stream_arbiter

Overview:
- Shares the single PE-array GLB input data bus between three producers: the ifmap, filter and ipsum GLB read streams.
- Selects one producer per packet (burst) by round-robin. Holds the grant until the packet's last beat.
- Registers data plus the matching X/Y tag into a one-entry output stage that drives the array's per-type valid/ready handshake.
- Sits between the GLB read engines and the PE array's GIN inputs.

Parameters:
DATA_SIZE, 32, data beat width
XID_BITS, 4, X tag width
YID_BITS, 3, Y tag width
MAX_BURST, 64, max beats per packet before forced release (power of 2, >=2)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset (0 = reset asserted)
src_valid  in  3  per-producer beat valid; bit0 ifmap, bit1 filter, bit2 ipsum
src_ready  out  3  per-producer beat accepted
src_last  in  3  beat is the last of its packet
src_data  in  3*DATA_SIZE  beat data; producer r occupies slice [r*DATA_SIZE +: DATA_SIZE]
src_tag_X  in  3*XID_BITS  X tag per producer, sliced as src_data
src_tag_Y  in  3*YID_BITS  Y tag per producer, sliced as src_data
GLB_ifmap_valid  out  1  output beat is ifmap
GLB_ifmap_ready  in  1  array accepts ifmap
GLB_filter_valid  out  1  output beat is filter
GLB_filter_ready  in  1  array accepts filter
GLB_ipsum_valid  out  1  output beat is ipsum
GLB_ipsum_ready  in  1  array accepts ipsum
GLB_data_in  out  DATA_SIZE  registered beat data
ifmap_tag_X / ifmap_tag_Y  out  XID_BITS / YID_BITS  tag for ifmap beats
filter_tag_X / filter_tag_Y  out  XID_BITS / YID_BITS  tag for filter beats
ipsum_tag_X / ipsum_tag_Y  out  XID_BITS / YID_BITS  tag for ipsum beats
busy  out  1  grant held or output stage full
err_overrun  out  1  sticky: a packet exceeded MAX_BURST beats

Behaviour:
- Reset (rst=0, async): all outputs, tags, data, src_ready, rr pointer (=0, ifmap first), beat counter, err_overrun and FSM are cleared to 0/IDLE immediately.
  - Reset asserted mid-packet discards the in-flight beat and the grant.
- Output stage: one entry (out_full, out_type, data, tag).
  - out_fire = out_full && ready of out_type.
  - load = !out_full || out_fire, giving full throughput of 1 beat/cycle.
  - Exactly one GLB_*_valid is high, and only while out_full.
  - Data and tags are stable while valid && !ready.
- Only the tag pair of the loaded type updates on load; the other pairs hold their values.
- FSM states:
  - IDLE:
    - Winner = first requester with src_valid in order rr, rr+1, rr+2 (mod 3).
    - src_ready[winner] = load. Its beat is accepted the same cycle.
    - If the beat is not last, go to OWN.
  - OWN:
    - Only the granted producer sees src_ready = load; the others see 0.
    - src_valid low in OWN is a bubble; the grant is held.
- Packet end: when a beat with src_last=1 is accepted, rr <= winner+1 (mod 3) and the FSM goes to IDLE.
  - IDLE may grant again the very next cycle, so there are no bubbles between packets.
- Single-beat packet (last on the first beat) stays in IDLE and rotates rr.
- Beat counter: counts accepted beats in the current packet.
  - If the MAX_BURST-th beat is accepted with src_last=0: force packet end (rotate rr, go to IDLE) and set err_overrun (sticky until reset).
- Latency: 1 cycle from src accept to GLB_*_valid.
- Simultaneous events: load on the same cycle as out_fire replaces the entry with no bubble.
  - A ready input for a type that is not valid is ignored.
- busy = (state==OWN) || out_full.

Test Plan:
- Single producer, no contention:
  - Stimulus: ifmap sends a 4-beat packet (data 1..4, tag X=2 Y=1, last on beat 4); all readies=1.
  - Response: GLB_ifmap_valid high on cycles 1-4 with data 1..4; ifmap_tag_X=2, ifmap_tag_Y=1; busy drops at cycle 5.
- Round-robin fairness:
  - Stimulus: all three producers continuously offer 2-beat packets.
  - Response: output type order is ifmap, ifmap, filter, filter, ipsum, ipsum, ifmap...; no idle cycles.
- Backpressure:
  - Stimulus: GLB_filter_ready=0 for 3 cycles mid-packet.
  - Response: GLB_filter_valid, data and tag hold steady; src_ready[1]=0 during the stall; no beat lost or duplicated.
- Grant lock:
  - Stimulus: ipsum asserts valid while a filter packet has a bubble (src_valid[1]=0).
  - Response: src_ready[2] stays 0 until the filter last beat is accepted.
- Overrun:
  - Stimulus: MAX_BURST=4; ifmap sends 6 beats with no last, filter waiting.
  - Response: after beat 4, err_overrun=1 and filter is granted next.
- Mid-packet reset:
  - Stimulus: rst=0 during beat 2 of a packet.
  - Response: all valids, src_ready and busy are 0 immediately; after release, rr=0 and the next grant is ifmap.

Source files
------------

// File: rtl/glb_stream_arbiter.sv
// Round-robin packet arbiter that merges the ifmap/filter/ipsum GLB read streams
// onto the shared PE-array input bus through a one-entry registered output stage.
module glb_stream_arbiter #(
  parameter int unsigned DATA_SIZE = 32,
  parameter int unsigned XID_BITS  = 4,
  parameter int unsigned YID_BITS  = 3,
  parameter int unsigned MAX_BURST = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [2:0]             src_valid,
  output logic [2:0]             src_ready,
  input  logic [2:0]             src_last,
  input  logic [3*DATA_SIZE-1:0] src_data,
  input  logic [3*XID_BITS-1:0]  src_tag_X,
  input  logic [3*YID_BITS-1:0]  src_tag_Y,
  output logic                   GLB_ifmap_valid,
  input  logic                   GLB_ifmap_ready,
  output logic                   GLB_filter_valid,
  input  logic                   GLB_filter_ready,
  output logic                   GLB_ipsum_valid,
  input  logic                   GLB_ipsum_ready,
  output logic [DATA_SIZE-1:0]   GLB_data_in,
  output logic [XID_BITS-1:0]    ifmap_tag_X,
  output logic [YID_BITS-1:0]    ifmap_tag_Y,
  output logic [XID_BITS-1:0]    filter_tag_X,
  output logic [YID_BITS-1:0]    filter_tag_Y,
  output logic [XID_BITS-1:0]    ipsum_tag_X,
  output logic [YID_BITS-1:0]    ipsum_tag_Y,
  output logic                   busy,
  output logic                   err_overrun
);
  localparam int unsigned CW = $clog2(MAX_BURST);

  typedef enum logic {IDLE = 1'b0, OWN = 1'b1} state_t;

  state_t          state;
  logic [1:0]      rr, owner, winner, sel;
  logic [CW-1:0]   cnt, beats;
  logic [2:0]      out_valid, glb_ready;
  logic            out_fire, load, granted, acc, at_limit, overrun, pkt_end;
  logic [DATA_SIZE-1:0] sel_data;
  logic [XID_BITS-1:0]  sel_tx;
  logic [YID_BITS-1:0]  sel_ty;

  function automatic logic [1:0] inc3(input logic [1:0] x);
    return (x == 2'd2) ? 2'd0 : x + 2'd1;
  endfunction

  assign glb_ready        = {GLB_ipsum_ready, GLB_filter_ready, GLB_ifmap_ready};
  assign GLB_ifmap_valid  = out_valid[0];
  assign GLB_filter_valid = out_valid[1];
  assign GLB_ipsum_valid  = out_valid[2];

  // Grant selection, source handshake and packet-end detection.
  always_comb begin
    out_fire = |(out_valid & glb_ready);
    load     = !(|out_valid) || out_fire;
    if (src_valid[rr])              winner = rr;
    else if (src_valid[inc3(rr)])   winner = inc3(rr);
    else                            winner = inc3(inc3(rr));
    sel       = (state == OWN) ? owner : winner;
    granted   = (state == OWN) || (|src_valid);
    src_ready = (rst && load && granted) ? (3'b001 << sel) : 3'b000;
    acc       = load && granted && src_valid[sel];
    beats     = (state == OWN) ? cnt : '0;
    at_limit  = (beats == CW'(MAX_BURST - 1));
    overrun   = acc && !src_last[sel] && at_limit;
    pkt_end   = acc && (src_last[sel] || at_limit);
    case (sel)
      2'd1: begin
        sel_data = src_data[DATA_SIZE +: DATA_SIZE];
        sel_tx   = src_tag_X[XID_BITS +: XID_BITS];
        sel_ty   = src_tag_Y[YID_BITS +: YID_BITS];
      end
      2'd2: begin
        sel_data = src_data[2*DATA_SIZE +: DATA_SIZE];
        sel_tx   = src_tag_X[2*XID_BITS +: XID_BITS];
        sel_ty   = src_tag_Y[2*YID_BITS +: YID_BITS];
      end
      default: begin
        sel_data = src_data[0 +: DATA_SIZE];
        sel_tx   = src_tag_X[0 +: XID_BITS];
        sel_ty   = src_tag_Y[0 +: YID_BITS];
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      rr           <= '0;
      owner        <= '0;
      cnt          <= '0;
      out_valid    <= '0;
      GLB_data_in  <= '0;
      ifmap_tag_X  <= '0;
      ifmap_tag_Y  <= '0;
      filter_tag_X <= '0;
      filter_tag_Y <= '0;
      ipsum_tag_X  <= '0;
      ipsum_tag_Y  <= '0;
      busy         <= 1'b0;
      err_overrun  <= 1'b0;
    end else begin
      if (pkt_end) begin
        state <= IDLE;
        rr    <= inc3(sel);
        cnt   <= '0;
      end else if (acc) begin
        state <= OWN;
        owner <= sel;
        cnt   <= beats + CW'(1);
      end
      if (overrun) err_overrun <= 1'b1;
      if (load) out_valid <= acc ? (3'b001 << sel) : 3'b000;
      // Only the tag pair of the loaded stream changes.
      if (acc) begin
        GLB_data_in <= sel_data;
        case (sel)
          2'd0: begin
            ifmap_tag_X <= sel_tx;
            ifmap_tag_Y <= sel_ty;
          end
          2'd1: begin
            filter_tag_X <= sel_tx;
            filter_tag_Y <= sel_ty;
          end
          default: begin
            ipsum_tag_X <= sel_tx;
            ipsum_tag_Y <= sel_ty;
          end
        endcase
      end
      busy <= (!pkt_end && (acc || state == OWN)) || (load ? acc : (|out_valid));
    end
  end
endmodule
